// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple slice with a
// registered carry, valid/ready handshakes on operand input and result output.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds in_valid and operands until accepted, and the result stays
  // stable with out_valid high until out_ready is sampled high.

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   slice;
  logic             last_dig;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = bx_q[i*DIGIT +: DIGIT];
      end
    end
    slice    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    last_dig = (k_q == KW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    bx_d    = bx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          // Subtraction is a + ~b + 1, so the borrow-in flips into a carry-in.
          a_d     = a_i;
          bx_d    = sub_i ? ~b_i : b_i;
          carry_d = cin_i ^ sub_i;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[i*DIGIT +: DIGIT] = slice[DIGIT-1:0];
          end
        end
        carry_d = slice[DIGIT];
        if (last_dig) begin
          cout_d  = slice[DIGIT];
          ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (slice[DIGIT-1] != a_q[WIDTH-1]);
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE) && rst_ni;
  assign out_valid_o = (state_q == S_DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed table on DIGIT=4, backpressure and reset sequences,
// then random operands on DIGIT in {1,2,4,16} against an arithmetic reference model.
module tb_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic [15:0] sum       [4];
  logic        cout      [4];
  logic        ovf       [4];
  logic [1:0]  state     [4];

  int n_vec = 0;
  int n_bad = 0;
  logic [17:0] exp_q[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    serial_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .a_i         (a),
      .b_i         (b),
      .cin_i       (cin),
      .sub_i       (sub),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .sum_o       (sum[g]),
      .cout_o      (cout[g]),
      .ovf_o       (ovf[g]),
      .state_o     (state[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int n_of(input int g);
    int d;
    d = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
    return 16 / d;
  endfunction

  // reference model: {cout, ovf, sum} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb,
                                        input logic tc, input logic ts);
    int ua, ub, sa, sb, c, r, sr;
    logic co, ov;
    logic [15:0] s;
    ua = ta; ub = tb;
    sa = $signed(ta); sb = $signed(tb);
    c  = tc;
    if (!ts) begin
      r  = ua + ub + c;
      co = (r >= 65536);
      sr = sa + sb + c;
    end else begin
      r  = ua - ub - c;
      co = (ua >= ub + c);
      sr = sa - sb - c;
    end
    s  = r[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {co, ov, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic scramble();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  // wait for out_valid[g], counting edges since the accept edge (called just after it)
  task automatic wait_result(input int g, output logic [17:0] res, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid[g]) break;
      lat++;
    end
    res = {cout[g], ovf[g], sum[g]};
  endtask

  task automatic take_result(input int g);
    out_ready[g] = 1'b1;
    @(posedge clk); #1;
    out_ready[g] = 1'b0;
  endtask

  task automatic run_op(input int g, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tc, input logic ts,
                        output logic [17:0] res, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready[g], 1);
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid[g] = 1'b1;
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
    scramble();
    wait_result(g, res, lat);
    take_result(g);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [17:0] res;
    int lat;
    int seen;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int g = 0; g < 4; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", in_ready[2], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset_in_ready_%0d", g), in_ready[g], 1);
      check($sformatf("reset_out_valid_%0d", g), out_valid[g], 0);
      check($sformatf("reset_result_%0d", g), {cout[g], ovf[g], sum[g]}, 0);
    end

    // directed table on DIGIT=4
    for (int i = 0; i < 9; i++) begin
      run_op(2, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, res, lat);
      check($sformatf("tbl%0d_sum", i), res[15:0], tbl[i].sum);
      check($sformatf("tbl%0d_cout", i), res[17], tbl[i].cout);
      check($sformatf("tbl%0d_ovf", i), res[16], tbl[i].ovf);
      check($sformatf("tbl%0d_latency", i), lat, 4);
    end

    // backpressure: hold the result 5 cycles while a second operand waits
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    in_valid[2] = 1'b1;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h0101;
    wait_result(2, res, lat);
    check("bp_first_result", res, {2'b00, 16'h3333});
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid_%0d", i), out_valid[2], 1);
      check($sformatf("bp_hold_result_%0d", i), {cout[2], ovf[2], sum[2]}, {2'b00, 16'h3333});
      check($sformatf("bp_hold_in_ready_%0d", i), in_ready[2], 0);
      @(negedge clk);
    end
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    out_ready[2] = 1'b0;
    @(negedge clk);
    check("bp_idle_in_ready", in_ready[2], 1);
    check("bp_idle_out_valid", out_valid[2], 0);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    scramble();
    wait_result(2, res, lat);
    check("bp_second_latency", lat, 4);
    check("bp_second_result", res, {2'b00, 16'h1010});
    take_result(2);

    // reset while RUN is at digit 2
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; sub = 1'b0;
    in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready_low", in_ready[2], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid[2], 0);
    check("rst_sum", sum[2], 16'h0000);
    check("rst_in_ready", in_ready[2], 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[2]) seen++;
    end
    check("rst_no_result", seen, 0);
    run_op(2, 16'h0001, 16'h0001, 1'b0, 1'b0, res, lat);
    check("rst_after_result", res, {2'b00, 16'h0002});
    check("rst_after_latency", lat, 4);

    // random sweep, all four DIGIT variants in lockstep
    for (int it = 0; it < 1000; it++) begin
      int lat_g[4];
      logic [17:0] res_g[4];
      int j;
      logic all_seen;
      @(negedge clk);
      scramble();
      exp_q.push_back(model(a, b, cin, sub));
      for (int g = 0; g < 4; g++) in_valid[g] = 1'b1;
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        in_valid[g] = 1'b0;
        lat_g[g] = -1;
        res_g[g] = '0;
      end
      scramble();
      j = 0;
      all_seen = 1'b0;
      while (j < 40 && !all_seen) begin
        @(negedge clk);
        all_seen = 1'b1;
        for (int g = 0; g < 4; g++) begin
          if (lat_g[g] < 0 && out_valid[g]) begin
            lat_g[g] = j;
            res_g[g] = {cout[g], ovf[g], sum[g]};
          end
          if (lat_g[g] < 0) all_seen = 1'b0;
        end
        j++;
      end
      for (int g = 0; g < 4; g++) begin
        check($sformatf("sweep%0d_n%0d_latency", it, n_of(g)), lat_g[g], n_of(g));
        check($sformatf("sweep%0d_n%0d_result", it, n_of(g)), res_g[g], exp_q[0]);
      end
      void'(exp_q.pop_front());
      for (int g = 0; g < 4; g++) out_ready[g] = 1'b1;
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) out_ready[g] = 1'b0;
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
